multi_cycle_control: RTL
========================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Clocking SHALL be one clock, clk_i; reset SHALL be rst_i, synchronous, active-high.
REQ-002 Parameter ALUOP_W, 2, alu_op_o width; SHALL be >= 2, with upper bits driven 0.
REQ-003 Parameter CNT_W, 32, retired-instruction counter width.
REQ-004 clk_i  input  1  clock; all state changes on rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 start_i  input  1  leave IDLE and begin fetching; sampled in IDLE only.
REQ-007 opcode_i  input  7  instruction opcode from IR; sampled in DECODE only.
REQ-008 funct7_i  input  7  instruction funct7 from IR; sampled in DECODE only.
REQ-009 mem_ready_i  input  1  memory access complete; sampled in FETCH and MEM only.
REQ-010 zero_i  input  1  ALU zero flag; sampled in EXEC for branches only.
REQ-011 mul_done_i  input  1  multiplier result valid.
REQ-012 pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, alu_src_o, mul_start_o  output  1 each  datapath strobes.
REQ-013 alu_op_o  output  ALUOP_W  00 add, 01 sub/compare, 10 R-type funct decode, 11 I-type funct decode.
REQ-014 state_o  output  3  current state encoding; illegal_o  output  1  sticky trap flag; instr_count_o  output  CNT_W  retired-instruction count.

Function
REQ-015 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; encoding 7 SHALL go to IDLE next cycle.
REQ-016 Outputs SHALL be combinational decode of registered state and registered opcode/funct7 (opc_q, f7_q) only; no input-to-output paths except pc_write_o in EXEC (zero_i) and FETCH (mem_ready_i) and ir_write_o in FETCH (mem_ready_i).
REQ-017 IDLE: all strobes 0; start_i=1 -> FETCH.
REQ-018 FETCH: mem_read_o=1; while mem_ready_i=0 stay; on mem_ready_i=1 assert ir_write_o=1 and pc_write_o=1 that cycle, -> DECODE.
REQ-019 DECODE: latch opcode_i into opc_q and funct7_i into f7_q; legal opcodes 0110011, 0010011, 0000011, 0100011, 1100011 -> EXEC; any other -> TRAP.
REQ-020 EXEC R-type: alu_src_o=0, alu_op_o=10, -> WB; I-type: alu_src_o=1, alu_op_o=11, -> WB.
REQ-021 EXEC load/store: alu_src_o=1, alu_op_o=00, -> MEM.
REQ-022 EXEC branch: alu_src_o=0, alu_op_o=01; pc_write_o=zero_i; -> FETCH; instruction retires.
REQ-023 MEM load: mem_read_o=1 until mem_ready_i=1, then -> WB; store: mem_write_o=1 until mem_ready_i=1, then -> FETCH and retire.
REQ-024 WB: reg_write_o=1 for exactly one cycle; mem_to_reg_o=1 for loads only; -> FETCH and retire.
REQ-025 Retire SHALL increment instr_count_o by 1 on the transition edge; count wraps 2^CNT_W-1 -> 0.
REQ-026 TRAP: illegal_o=1, all strobes 0, state held until rst_i; start_i ignored.
REQ-027 mem_ready_i in any state other than FETCH/MEM SHALL be ignored; a pending mem_ready_i SHALL NOT be remembered.

Reset
REQ-028 rst_i=1 in any state, including mid-FETCH/MEM wait, SHALL force IDLE, opc_q=0, f7_q=0, instr_count_o=0, illegal_o=0 and all strobes 0 on the next edge; rst_i overrides start_i.

Configuration
REQ-029 Macro CTRL_MUL_EN defined: R-type with f7_q=0000001 in EXEC asserts mul_start_o=1 for its first EXEC cycle only, stays in EXEC until mul_done_i=1, then -> WB; alu_op_o=10 throughout.
REQ-030 CTRL_MUL_EN undefined: R-type with funct7_i=0000001 SHALL be illegal in DECODE -> TRAP; mul_start_o tied 0; mul_done_i ignored.

Verification
REQ-031 Reset, start_i=1, R-type (0110011), mem_ready_i=1 immediately -> states 1,2,3,5,1; reg_write_o one cycle; instr_count_o=1.
REQ-032 Load with mem_ready_i delayed 3 cycles in FETCH and MEM -> FETCH and MEM each held 4 cycles; mem_to_reg_o=1 in WB; count=1.
REQ-033 Branch with zero_i=1 then zero_i=0 -> pc_write_o=1 in EXEC only for first; both retire, count=2, no WB visited.
REQ-034 Opcode 1111111 -> TRAP, illegal_o=1 held 10 cycles with start_i=1; rst_i=1 -> IDLE, illegal_o=0.
REQ-035 CNT_W=4, 16 I-type instructions -> instr_count_o wraps to 0; rst_i asserted mid-MEM wait -> IDLE next cycle, count 0.
REQ-036 funct7_i=0000001 R-type: with CTRL_MUL_EN, mul_start_o one cycle, mul_done_i after 5 cycles -> WB; without, -> TRAP.

Source files
------------

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle CPU control FSM; optional multiplier sequencing via CTRL_MUL_EN
module multi_cycle_control #(
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [6:0]         opcode_i,
  input  logic [6:0]         funct7_i,
  input  logic               mem_ready_i,
  input  logic               zero_i,
  input  logic               mul_done_i,
  output logic               pc_write_o,
  output logic               ir_write_o,
  output logic               reg_write_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               mem_to_reg_o,
  output logic               alu_src_o,
  output logic               mul_start_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic [2:0]         state_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   instr_count_o
);

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_BAD    = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       opc_q, opc_d;
  logic [6:0]       f7_q, f7_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             retire;
  logic             dec_legal;
  logic [1:0]       alu_op;

`ifdef CTRL_MUL_EN
  logic mul_first_q;

  // Flags the first EXEC cycle so the multiplier is kicked exactly once
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mul_first_q <= 1'b0;
    end else begin
      mul_first_q <= (state_q == S_DECODE);
    end
  end
`else
  logic unused_mul;
  assign unused_mul = ^{mul_done_i, f7_q};
`endif

  // Legality of the live IR fields, only meaningful while in DECODE
  always_comb begin
    dec_legal = 1'b0;
    case (opcode_i)
`ifdef CTRL_MUL_EN
      OPC_R:                         dec_legal = 1'b1;
`else
      OPC_R:                         dec_legal = (funct7_i != F7_MUL);
`endif
      OPC_I, OPC_LD, OPC_ST, OPC_BR: dec_legal = 1'b1;
      default:                       dec_legal = 1'b0;
    endcase
  end

  // Next-state, datapath strobes and retire decode from registered state
  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    f7_d         = f7_q;
    illegal_d    = illegal_q;
    retire       = 1'b0;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_o    = 1'b0;
    mul_start_o  = 1'b0;
    alu_op       = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        opc_d     = opcode_i;
        f7_d      = funct7_i;
        state_d   = dec_legal ? S_EXEC : S_TRAP;
        illegal_d = !dec_legal;
      end
      S_EXEC: begin
        case (opc_q)
          OPC_R: begin
            alu_op = 2'b10;
`ifdef CTRL_MUL_EN
            if (f7_q == F7_MUL) begin
              mul_start_o = mul_first_q;
              if (mul_done_i) state_d = S_WB;
            end else begin
              state_d = S_WB;
            end
`else
            state_d = S_WB;
`endif
          end
          OPC_I: begin
            alu_src_o = 1'b1;
            alu_op    = 2'b11;
            state_d   = S_WB;
          end
          OPC_LD, OPC_ST: begin
            alu_src_o = 1'b1;
            state_d   = S_MEM;
          end
          OPC_BR: begin
            alu_op     = 2'b01;
            pc_write_o = zero_i;
            state_d    = S_FETCH;
            retire     = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_MEM: begin
        if (opc_q == OPC_LD) begin
          mem_read_o = 1'b1;
          if (mem_ready_i) state_d = S_WB;
        end else if (opc_q == OPC_ST) begin
          mem_write_o = 1'b1;
          if (mem_ready_i) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = (opc_q == OPC_LD);
        state_d      = S_FETCH;
        retire       = 1'b1;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State, latched IR fields, retire counter and trap flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      opc_q     <= 7'd0;
      f7_q      <= 7'd0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      f7_q      <= f7_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign alu_op_o      = ALUOP_W'(alu_op);
  assign state_o       = state_q;
  assign illegal_o     = illegal_q;
  assign instr_count_o = cnt_q;

endmodule
